// File: rtl/ult_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ult_scheduler_pkg : shared types and helpers for the ultimate scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package ult_scheduler_pkg;

   localparam int ENERGY_W = 10;
   localparam int P1       = 0;
   localparam int P2       = 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FIRE     = 2'd1,
      ACTIVE   = 2'd2,
      COOLDOWN = 2'd3
   } ult_state_t;

   // Sum is formed one bit wider so the clamp sees any overflow past lim.
   function automatic logic [ENERGY_W-1:0] sat_add(
      input logic [ENERGY_W-1:0] base,
      input logic [ENERGY_W-1:0] inc,
      input logic [ENERGY_W-1:0] lim
   );
      logic [ENERGY_W:0] sum;
      sum = {1'b0, base} + {1'b0, inc};
      return (sum >= {1'b0, lim}) ? lim : sum[ENERGY_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ult_scheduler_energy_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ult_scheduler_energy_meter : per-player saturating energy accumulator
// Rev 1.0
// ---------------------------------------------------------------------------
module ult_scheduler_energy_meter
   import ult_scheduler_pkg::*;
#(
   parameter int MAX   = 600,
   parameter int BONUS = 60
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                clear,
   input  logic                bonus,
   output logic [ENERGY_W-1:0] energy,
   output logic                full
);

   localparam logic [ENERGY_W-1:0] MAX_V   = ENERGY_W'(MAX);
   localparam logic [ENERGY_W-1:0] BONUS_V = ENERGY_W'(BONUS);

   // A credited hit replaces that frame's charge tick with the bonus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         energy <= '0;
      end else if (clear) begin
         energy <= '0;
      end else if (enable) begin
         energy <= sat_add(energy, bonus ? BONUS_V : ENERGY_W'(1), MAX_V);
      end
   end

   assign full = (energy == MAX_V);

endmodule
`default_nettype wire

// File: rtl/ult_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ult_scheduler : arbitrates the shared pulse-bomb slot between two players
// Rev 1.0
// ---------------------------------------------------------------------------
module ult_scheduler
   import ult_scheduler_pkg::*;
#(
   parameter int         ENERGY_MAX = 600,
   parameter int         HIT_BONUS  = 60,
   parameter int         COOLDOWN_N = 30,
   parameter int         ACTIVE_MAX = 240,
   parameter logic [1:0] ULT_ID     = 2'd0
) (
   input  logic                frame_clk,
   input  logic                Reset_n,
   input  logic [1:0]          press_u,
   input  logic [1:0]          chara_id0,
   input  logic [1:0]          chara_id1,
   input  logic [1:0]          alive,
   input  logic                bomb_active,
   input  logic                bomb_hit_evt,
   input  logic                boom_hit_evt,
   output logic                fire,
   output logic                owner,
   output logic [1:0]          full_energy,
   output logic [ENERGY_W-1:0] energy0,
   output logic [ENERGY_W-1:0] energy1,
   output logic [1:0]          hit_credit,
   output logic [1:0]          splash_credit,
   output logic                busy
);

   localparam logic [ENERGY_W-1:0] ACT_LAST = ENERGY_W'(ACTIVE_MAX - 1);
   localparam logic [ENERGY_W-1:0] CD_LAST  = ENERGY_W'(COOLDOWN_N - 1);

   ult_state_t          state;
   logic [ENERGY_W-1:0] count;
   logic                last_grant;
   logic [1:0]          press_q;
   logic [1:0]          rise;
   logic [1:0]          ult_sel;
   logic [1:0]          req;
   logic [1:0]          full;
   logic [1:0]          clear;
   logic [1:0]          bonus;
   logic                grant;
   logic                winner;
   logic                credit_ok;
   logic [ENERGY_W-1:0] energy [2];

   assign rise    = press_u & ~press_q;
   assign ult_sel = {chara_id1 == ULT_ID, chara_id0 == ULT_ID};
   assign req     = rise & alive & full & ult_sel;

   always_comb begin
      grant  = (state == IDLE) && (req != 2'b00);
      winner = 1'b0;
      if (req == 2'b11) begin
         winner = ~last_grant;
      end else begin
         winner = req[P2];
      end
      clear = 2'b00;
      if (grant) begin
         clear = winner ? 2'b10 : 2'b01;
      end
   end

   // Late BOOM events during COOLDOWN still belong to the owner.
   assign credit_ok = (state == ACTIVE) || (state == COOLDOWN);

   always_comb begin
      hit_credit    = 2'b00;
      splash_credit = 2'b00;
      if (credit_ok && bomb_hit_evt) begin
         hit_credit = owner ? 2'b10 : 2'b01;
      end else if (credit_ok && boom_hit_evt) begin
         splash_credit = owner ? 2'b10 : 2'b01;
      end
   end

   assign bonus = hit_credit | splash_credit;

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         count      <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         press_q    <= 2'b00;
      end else begin
         press_q <= press_u;
         case (state)
            IDLE: begin
               count <= '0;
               if (grant) begin
                  owner      <= winner;
                  last_grant <= winner;
                  state      <= FIRE;
               end
            end
            FIRE: begin
               count <= '0;
               state <= ACTIVE;
            end
            ACTIVE: begin
               // count>=1 masks the frame before the projectile reports active
               if ((!bomb_active && count != '0) || count == ACT_LAST) begin
                  count <= '0;
                  state <= COOLDOWN;
               end else begin
                  count <= count + 1'b1;
               end
            end
            COOLDOWN: begin
               if (count == CD_LAST) begin
                  count <= '0;
                  state <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               count <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_meter
      ult_scheduler_energy_meter #(
         .MAX   (ENERGY_MAX),
         .BONUS (HIT_BONUS)
      ) u_meter (
         .clk    (frame_clk),
         .rst_n  (Reset_n),
         .enable (alive[i]),
         .clear  (clear[i]),
         .bonus  (bonus[i]),
         .energy (energy[i]),
         .full   (full[i])
      );
   end

   assign fire        = (state == FIRE);
   assign busy        = (state != IDLE);
   assign full_energy = full;
   assign energy0     = energy[P1];
   assign energy1     = energy[P2];

endmodule
`default_nettype wire

// File: tb/tb_ult_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ult_scheduler : directed self-checking bench for ult_scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ult_scheduler;

   logic       frame_clk = 1'b0;
   logic       Reset_n;
   logic [1:0] press_u;
   logic [1:0] chara_id0;
   logic [1:0] chara_id1;
   logic [1:0] alive;
   logic       bomb_active;
   logic       bomb_hit_evt;
   logic       boom_hit_evt;
   logic       fire;
   logic       owner;
   logic [1:0] full_energy;
   logic [9:0] energy0;
   logic [9:0] energy1;
   logic [1:0] hit_credit;
   logic [1:0] splash_credit;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int fires;

   always #5 frame_clk = ~frame_clk;

   ult_scheduler dut (
      .frame_clk     (frame_clk),
      .Reset_n       (Reset_n),
      .press_u       (press_u),
      .chara_id0     (chara_id0),
      .chara_id1     (chara_id1),
      .alive         (alive),
      .bomb_active   (bomb_active),
      .bomb_hit_evt  (bomb_hit_evt),
      .boom_hit_evt  (boom_hit_evt),
      .fire          (fire),
      .owner         (owner),
      .full_energy   (full_energy),
      .energy0       (energy0),
      .energy1       (energy1),
      .hit_credit    (hit_credit),
      .splash_credit (splash_credit),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge frame_clk);
   endtask

   task automatic do_reset();
      Reset_n      = 1'b0;
      press_u      = 2'b00;
      chara_id0    = 2'd0;
      chara_id1    = 2'd0;
      alive        = 2'b11;
      bomb_active  = 1'b0;
      bomb_hit_evt = 1'b0;
      boom_hit_evt = 1'b0;
      tick(2);
      Reset_n = 1'b1;
   endtask

   initial begin
      // Basic fire, latency, credits, cooldown length
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_fire", fire, 0);
      check("rst_owner", owner, 0);
      check("rst_e0", energy0, 0);
      check("rst_credit", {hit_credit, splash_credit}, 0);
      tick(599);
      check("e0_599", energy0, 599);
      check("full_599", full_energy, 2'b00);
      tick(1);
      check("e0_600", energy0, 600);
      check("full_600", full_energy, 2'b11);
      tick(5);
      check("e0_sat", energy0, 600);
      press_u = 2'b01;
      #1 check("fire_pre", fire, 0);
      tick(1);
      check("fire_p1", fire, 1);
      check("owner_p1", owner, 0);
      check("e0_clr", energy0, 0);
      check("e1_keep", energy1, 600);
      press_u     = 2'b00;
      bomb_active = 1'b1;
      tick(1);
      check("fire_once", fire, 0);
      check("busy_act", busy, 1);
      check("e0_recharge", energy0, 1);
      bomb_hit_evt = 1'b1;
      #1 check("hit_cr", hit_credit, 2'b01);
      check("hit_nosplash", splash_credit, 2'b00);
      tick(1);
      bomb_hit_evt = 1'b0;
      check("e0_bonus", energy0, 61);
      #1 check("hit_cr_off", hit_credit, 2'b00);
      boom_hit_evt = 1'b1;
      #1 check("splash_cr", splash_credit, 2'b01);
      tick(1);
      boom_hit_evt = 1'b0;
      check("e0_splash", energy0, 121);
      bomb_active = 1'b0;
      tick(1);
      boom_hit_evt = 1'b1;
      #1 check("late_boom", splash_credit, 2'b01);
      tick(1);
      boom_hit_evt = 1'b0;
      check("e0_late", energy0, 182);
      tick(28);
      check("cd_busy", busy, 1);
      press_u = 2'b10;
      tick(1);
      check("cd_done", busy, 0);
      tick(1);
      check("cd_drop", busy, 0);
      press_u = 2'b00;

      // Holding the key never refires
      do_reset();
      tick(600);
      press_u = 2'b01;
      fires   = 0;
      for (int i = 0; i < 900; i++) begin
         tick(1);
         if (fire) fires++;
      end
      check("hold_fires", fires, 1);
      check("hold_e0", energy0, 600);
      press_u = 2'b00;

      // Qualification: not full, dead, wrong character
      do_reset();
      tick(598);
      alive = 2'b10;
      tick(1);
      check("dead_hold", energy0, 598);
      check("alive_e1", energy1, 599);
      alive = 2'b11;
      tick(1);
      check("e0_599b", energy0, 599);
      press_u = 2'b01;
      tick(1);
      check("nofire_599", busy, 0);
      press_u = 2'b00;
      tick(1);
      alive   = 2'b10;
      press_u = 2'b01;
      tick(1);
      check("nofire_dead", busy, 0);
      press_u = 2'b00;
      alive   = 2'b11;
      tick(1);
      chara_id0 = 2'd1;
      press_u   = 2'b01;
      tick(1);
      check("nofire_chara", busy, 0);
      press_u   = 2'b00;
      chara_id0 = 2'd0;
      tick(1);

      // Round-robin on simultaneous requests, launch guard length
      do_reset();
      tick(600);
      press_u = 2'b11;
      tick(1);
      check("rr1_fire", fire, 1);
      check("rr1_owner", owner, 0);
      check("rr1_e1", energy1, 600);
      press_u = 2'b00;
      tick(32);
      check("guard_busy", busy, 1);
      tick(1);
      check("guard_idle", busy, 0);
      tick(567);
      check("rr_e0_full", energy0, 600);
      press_u = 2'b11;
      tick(1);
      check("rr2_fire", fire, 1);
      check("rr2_owner", owner, 1);
      check("rr2_e1", energy1, 0);
      check("rr2_e0", energy0, 600);
      press_u = 2'b00;
      tick(1);
      bomb_hit_evt = 1'b1;
      boom_hit_evt = 1'b1;
      #1 check("p2_hit", hit_credit, 2'b10);
      check("p2_nosplash", splash_credit, 2'b00);
      tick(1);
      bomb_hit_evt = 1'b0;
      boom_hit_evt = 1'b0;
      check("p2_bonus", energy1, 61);

      // Watchdog retire and bonus saturation
      do_reset();
      tick(600);
      press_u     = 2'b01;
      bomb_active = 1'b1;
      tick(1);
      press_u = 2'b00;
      tick(1);
      bomb_hit_evt = 1'b1;
      tick(10);
      bomb_hit_evt = 1'b0;
      check("bonus_sat", energy0, 600);
      tick(259);
      check("wd_busy", busy, 1);
      tick(1);
      check("wd_idle", busy, 0);

      // Asynchronous reset during FIRE and ACTIVE
      press_u = 2'b01;
      tick(1);
      check("rf_fire", fire, 1);
      Reset_n = 1'b0;
      #1 check("rf_fire0", fire, 0);
      check("rf_busy0", busy, 0);
      check("rf_e0", energy0, 0);
      do_reset();
      tick(600);
      press_u = 2'b01;
      tick(2);
      check("ra_busy", busy, 1);
      Reset_n = 1'b0;
      #1 check("ra_busy0", busy, 0);
      check("ra_fire0", fire, 0);
      check("ra_owner", owner, 0);
      press_u = 2'b00;
      tick(1);
      Reset_n = 1'b1;
      tick(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
